// File: rtl/pll_reset_seq.sv
// pll_reset_seq: holds sys_rst until the PLL lock is stable, then releases it; re-arms on lock loss or button.
module pll_reset_seq #(
    parameter int LOCK_STABLE = 1024,
    parameter int RST_HOLD    = 256,
    parameter int DEBOUNCE    = 250000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       btn_reset_n,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] state
);
    localparam int PMAX = LOCK_STABLE > RST_HOLD ? LOCK_STABLE : RST_HOLD;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int DW   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} st_t;

    st_t         st, st_nx;
    logic [PW-1:0] cnt, cnt_nx;
    logic [7:0]  loss_nx;
    logic [1:0]  lock_sync, btn_sync;
    logic [DW-1:0] deb_cnt;
    logic        btn_db;
    logic        locked_s, btn_s;

    assign locked_s = lock_sync[1];
    assign btn_s    = btn_sync[1];

    // button chain stores the inverted level so a cleared chain reads as released
    always_ff @(posedge clk25) begin
        if (rst) begin
            lock_sync <= '0;
            btn_sync  <= '0;
            deb_cnt   <= '0;
            btn_db    <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
            btn_sync  <= {btn_sync[0], ~btn_reset_n};
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE - 1)) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            st            <= WAIT_LOCK;
            cnt           <= '0;
            lock_loss_cnt <= '0;
        end else begin
            st            <= st_nx;
            cnt           <= cnt_nx;
            lock_loss_cnt <= loss_nx;
        end
    end

    // lock loss outranks the button in every state
    always_comb begin
        st_nx   = st;
        cnt_nx  = cnt;
        loss_nx = lock_loss_cnt;
        case (st)
            WAIT_LOCK: begin
                if (locked_s) begin
                    st_nx  = STABLE;
                    cnt_nx = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    st_nx  = WAIT_LOCK;
                    cnt_nx = '0;
                end else if (cnt == PW'(LOCK_STABLE - 1)) begin
                    st_nx  = HOLD;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    st_nx  = WAIT_LOCK;
                    cnt_nx = '0;
                end else if (btn_db) begin
                    cnt_nx = '0;
                end else if (cnt == PW'(RST_HOLD - 1)) begin
                    st_nx  = RUN;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                if (!locked_s) begin
                    st_nx   = WAIT_LOCK;
                    cnt_nx  = '0;
                    loss_nx = lock_loss_cnt == 8'hff ? lock_loss_cnt : lock_loss_cnt + 1'b1;
                end else if (btn_db) begin
                    st_nx  = HOLD;
                    cnt_nx = '0;
                end
            end
        endcase
    end

    assign sys_rst = st != RUN;
    assign ready   = st == RUN;
    assign state   = st;
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed checks of release timing, lock loss, debounce and reset for pll_reset_seq.
module tb_pll_reset_seq;
    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       btn_reset_n = 1'b1;
    logic       sys_rst, ready;
    logic [7:0] lock_loss_cnt;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;
    int exp_loss = 0;

    pll_reset_seq #(.LOCK_STABLE(4), .RST_HOLD(3), .DEBOUNCE(8)) dut (
        .clk25(clk25), .rst(rst), .pll_locked(pll_locked), .btn_reset_n(btn_reset_n),
        .sys_rst(sys_rst), .ready(ready), .lock_loss_cnt(lock_loss_cnt), .state(state)
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    // lock drops for 10 cycles from RUN, then the full sequence runs back to RUN
    task automatic lose_lock();
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("ll_pre", 32'(state), 3);
        tick();
        chk("ll_state", 32'(state), 0);
        chk("ll_sysrst", 32'(sys_rst), 1);
        exp_loss = exp_loss < 255 ? exp_loss + 1 : 255;
        chk("ll_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
        repeat (7) tick();
        pll_locked = 1'b1;
        repeat (9) tick();
        chk("ll_hold", 32'(state), 2);
        tick();
        chk("ll_run", 32'(state), 3);
        chk("ll_ready", 32'(ready), 1);
    endtask

    initial begin
        logic [17:0] bounce;
        int e;
        pll_locked = 1'b1;
        repeat (5) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_sysrst", 32'(sys_rst), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_loss", 32'(lock_loss_cnt), 0);
        rst = 1'b0;
        for (int m = 0; m <= 10; m++) begin
            tick();
            e = m < 2 ? 0 : m < 6 ? 1 : m < 9 ? 2 : 3;
            chk($sformatf("rel_state_k%0d", m), 32'(state), 32'(e));
            chk($sformatf("rel_sysrst_k%0d", m), 32'(sys_rst), 32'(e != 3));
        end
        chk("rel_ready", 32'(ready), 1);

        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            tick();
            if (m == 3) pll_locked = 1'b0;
            e = m < 3 ? 0 : m < 6 ? 1 : 0;
            chk($sformatf("unst_state_%0d", m), 32'(state), 32'(e));
        end
        chk("unst_loss", 32'(lock_loss_cnt), 0);

        pll_locked = 1'b1;
        wait_state("to_run", 2'd3, 40);
        lose_lock();

        bounce = 18'b000110001111111111;
        for (int i = 17; i >= 0; i--) begin
            btn_reset_n = bounce[i];
            tick();
            chk("bounce", 32'(state), 3);
        end
        btn_reset_n = 1'b0;
        for (int m = 1; m <= 20; m++) begin
            tick();
            chk($sformatf("press_%0d", m), 32'(state), m < 11 ? 3 : 2);
        end
        chk("press_sysrst", 32'(sys_rst), 1);
        btn_reset_n = 1'b1;
        for (int m = 1; m <= 15; m++) begin
            tick();
            chk($sformatf("release_%0d", m), 32'(state), m < 13 ? 2 : 3);
        end

        btn_reset_n = 1'b0;
        repeat (8) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("simul_pre", 32'(state), 3);
        tick();
        chk("simul_state", 32'(state), 0);
        exp_loss = 2;
        chk("simul_loss", 32'(lock_loss_cnt), 2);
        pll_locked = 1'b1;
        repeat (10) tick();
        chk("held_hold", 32'(state), 2);
        chk("held_loss", 32'(lock_loss_cnt), 2);

        rst = 1'b1;
        tick();
        chk("mid_state", 32'(state), 0);
        chk("mid_loss", 32'(lock_loss_cnt), 0);
        chk("mid_sysrst", 32'(sys_rst), 1);
        rst = 1'b0;
        btn_reset_n = 1'b1;
        exp_loss = 0;
        wait_state("mid_run", 2'd3, 60);

        for (int i = 0; i < 300; i++) lose_lock();
        chk("sat_loss", 32'(lock_loss_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
